// File: rtl/maxpool_flatten.sv
// ============================================================================
// Module   : maxpool_flatten
// Purpose  : 2x2/stride-2 max-pool of two 64x64 L0 maps into the L1 banks,
//            plus the channel-interleaved flatten vector into the L2 bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_flatten #(
    parameter int DW   = 20,
    parameter int AW   = 12,
    parameter int IN_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int OW = IN_W / 2;
    localparam int CW = $clog2(OW);
    localparam int IW = 2 * CW;
    localparam logic [IW-1:0] C_I_LAST = {IW{1'b1}};

    localparam logic [2:0] C_SEL_IDLE = 3'b000;
    localparam logic [2:0] C_SEL_L0K0 = 3'b001;
    localparam logic [2:0] C_SEL_L0K1 = 3'b010;
    localparam logic [2:0] C_SEL_L1K0 = 3'b011;
    localparam logic [2:0] C_SEL_L2   = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR1  = 3'd2,
        S_WR2  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          k_q;
    logic [1:0]    sub_q;
    logic [DW-1:0] max_q;
    logic [DW-1:0] max_d;

    // Window address {row, dy, col, dx}: equals 2*r*IN_W + 2*c + {0,1,IN_W,IN_W+1}.
    function automatic logic [AW-1:0] rd_addr(input logic [IW-1:0] idx, input logic [1:0] sub);
        return AW'({idx[IW-1:CW], sub[1], idx[CW-1:0], sub[0]});
    endfunction

    // First sample of a window reloads the maximum so nothing stale is compared.
    always_comb begin
        max_d = max_q;
        if (sub_q == 2'd0) begin
            max_d = cdata_rd;
        end else if ($signed(cdata_rd) > $signed(max_q)) begin
            max_d = cdata_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            k_q      <= 1'b0;
            sub_q    <= 2'd0;
            max_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= C_SEL_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RD;
                        busy     <= 1'b1;
                        idx_q    <= '0;
                        k_q      <= 1'b0;
                        sub_q    <= 2'd0;
                        crd      <= 1'b1;
                        csel     <= C_SEL_L0K0;
                        caddr_rd <= rd_addr('0, 2'd0);
                    end
                end
                S_RD: begin
                    max_q <= max_d;
                    if (sub_q != 2'd3) begin
                        sub_q    <= sub_q + 2'd1;
                        caddr_rd <= rd_addr(idx_q, sub_q + 2'd1);
                    end else begin
                        sub_q    <= 2'd0;
                        state_q  <= S_WR1;
                        crd      <= 1'b0;
                        cwr      <= 1'b1;
                        csel     <= C_SEL_L1K0 + {2'b00, k_q};
                        caddr_wr <= AW'(idx_q);
                        cdata_wr <= max_d;
                    end
                end
                S_WR1: begin
                    state_q  <= S_WR2;
                    csel     <= C_SEL_L2;
                    caddr_wr <= AW'({idx_q, k_q});
                end
                S_WR2: begin
                    cwr <= 1'b0;
                    if (!k_q) begin
                        state_q  <= S_RD;
                        k_q      <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= C_SEL_L0K1;
                        caddr_rd <= rd_addr(idx_q, 2'd0);
                    end else if (idx_q != C_I_LAST) begin
                        state_q  <= S_RD;
                        k_q      <= 1'b0;
                        idx_q    <= idx_q + IW'(1);
                        crd      <= 1'b1;
                        csel     <= C_SEL_L0K0;
                        caddr_rd <= rd_addr(idx_q + IW'(1), 2'd0);
                    end else begin
                        state_q <= S_FIN;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        csel    <= C_SEL_IDLE;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maxpool_flatten.sv
// ============================================================================
// Module   : tb_maxpool_flatten
// Purpose  : Scoreboard bench for maxpool_flatten with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_flatten;

    localparam int DW   = 20;
    localparam int AW   = 12;
    localparam int IN_W = 64;
    localparam int NPIX = (IN_W / 2) * (IN_W / 2);

    typedef struct packed {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    logic [DW-1:0] m0 [4096];
    logic [DW-1:0] m1 [4096];
    logic [DW-1:0] l1 [2][NPIX];
    logic [DW-1:0] l2 [2*NPIX];
    logic [DW-1:0] exp_l1 [2][NPIX];
    logic [DW-1:0] exp_l2 [2*NPIX];

    txn_t exp_rd[$];
    txn_t exp_wr[$];

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int offs [4]    = '{0, 1, IN_W, IN_W + 1};

    maxpool_flatten #(.DW(DW), .AW(AW), .IN_W(IN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cdata_rd = !crd ? '0 :
                      (csel == 3'b001) ? m0[caddr_rd] :
                      (csel == 3'b010) ? m1[caddr_rd] : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: every window maximum from plain signed arithmetic, in issue order.
    task automatic build_expected();
        for (int i = 0; i < NPIX; i++) begin
            for (int k = 0; k < 2; k++) begin
                int r;
                int c;
                int base;
                int best;
                r    = i / (IN_W / 2);
                c    = i % (IN_W / 2);
                base = 2 * r * IN_W + 2 * c;
                best = 0;
                for (int s = 0; s < 4; s++) begin
                    int a;
                    int v;
                    a = base + offs[s];
                    v = int'($signed(k == 1 ? m1[a] : m0[a]));
                    if (s == 0 || v > best) best = v;
                    exp_rd.push_back('{sel: 3'(1 + k), addr: AW'(a), data: '0});
                end
                exp_l1[k][i]      = DW'(best);
                exp_l2[2 * i + k] = DW'(best);
                exp_wr.push_back('{sel: 3'(3 + k), addr: AW'(i), data: DW'(best)});
                exp_wr.push_back('{sel: 3'b101, addr: AW'(2 * i + k), data: DW'(best)});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            txn_t t;
            chk("strobe_excl", 64'(crd & cwr), 64'd0);
            if (!crd && !cwr) chk("idle_csel", 64'(csel), 64'd0);
            if (crd) begin
                if (exp_rd.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_unexpected: got sel %0h addr %0h, expected no read", csel, caddr_rd);
                end else begin
                    t = exp_rd.pop_front();
                    chk("rd_sel", 64'(csel), 64'(t.sel));
                    chk("rd_addr", 64'(caddr_rd), 64'(t.addr));
                end
            end
            if (cwr) begin
                wr_count++;
                if (csel == 3'b011) l1[0][caddr_wr[9:0]] = cdata_wr;
                if (csel == 3'b100) l1[1][caddr_wr[9:0]] = cdata_wr;
                if (csel == 3'b101) l2[caddr_wr[10:0]] = cdata_wr;
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wr_unexpected: got sel %0h addr %0h, expected no write", csel, caddr_wr);
                end else begin
                    t = exp_wr.pop_front();
                    chk("wr_sel", 64'(csel), 64'(t.sel));
                    chk("wr_addr", 64'(caddr_wr), 64'(t.addr));
                    chk("wr_data", 64'(cdata_wr), 64'(t.data));
                end
            end
        end
    end

    task automatic load_ramp();
        for (int a = 0; a < 4096; a++) begin
            m0[a] = DW'(a);
            m1[a] = DW'(a);
        end
    endtask

    // Mix of full-range values and a tiny range so ties occur often.
    task automatic load_random();
        for (int a = 0; a < 4096; a++) begin
            m0[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            m1[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        end
    endtask

    task automatic check_image();
        int bad;
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (l1[0][i] !== exp_l1[0][i]) bad++;
            if (l1[1][i] !== exp_l1[1][i]) bad++;
            if (l2[2 * i] !== exp_l2[2 * i]) bad++;
            if (l2[2 * i + 1] !== exp_l2[2 * i + 1]) bad++;
        end
        chk("final_image", 64'(bad), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge of the idle cycle after done.
    task automatic run_pass(input int inj1, input int inj2, input int abort_at);
        int done_at;
        int busy_cnt;
        int done_cnt;
        int wr_snap;
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        exp_rd.delete();
        exp_wr.delete();
        build_expected();
        wr_count = 0;
        start    = 1'b1;
        for (int n = 0; n < 12290; n++) begin
            @(posedge clk);
            if (n == abort_at) begin
                #3 reset = 1'b1;
                #1;
                chk("abort_outputs", 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
                exp_rd.delete();
                exp_wr.delete();
                wr_snap = wr_count;
                start   = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (20) @(negedge clk);
                chk("abort_no_writes", 64'(wr_count), 64'(wr_snap));
                chk("abort_idle_busy", 64'({busy, done}), 64'd0);
                return;
            end
            @(negedge clk);
            start = (n == inj1 || n == inj2);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
        end
        start = 1'b0;
        chk("busy_cycles", 64'(busy_cnt), 64'd12288);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("done_latency", 64'(done_at), 64'd12288);
        chk("write_count", 64'(wr_count), 64'd4096);
        chk("queues_drained", 64'(exp_rd.size() + exp_wr.size()), 64'd0);
        check_image();
    endtask

    task automatic check_ramp();
        chk("ramp_l1k0_0", 64'(l1[0][0]), 64'h00041);
        chk("ramp_l1k1_1023", 64'(l1[1][1023]), 64'h00FFF);
        chk("ramp_l2_0", 64'(l2[0]), 64'h00041);
        chk("ramp_l2_2047", 64'(l2[2047]), 64'h00FFF);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        load_ramp();
        run_pass(-1, -1, -1);
        check_ramp();

        // Signed window maxima at i = 0, with restart attempts while busy.
        load_random();
        m0[0]  = 20'h80000;
        m0[1]  = 20'hFFFFF;
        m0[64] = 20'h00001;
        m0[65] = 20'h7FFFF;
        m1[0]  = 20'hFFFFF;
        m1[1]  = 20'hFFFFF;
        m1[64] = 20'hFFFFF;
        m1[65] = 20'hFFFFF;
        repeat (2) @(negedge clk);
        run_pass(100, 5000, -1);
        chk("signed_max_k0", 64'(l1[0][0]), 64'h7FFFF);
        chk("all_neg_k1", 64'(l1[1][0]), 64'hFFFFF);

        load_ramp();
        repeat (2) @(negedge clk);
        run_pass(-1, -1, 3000);
        run_pass(-1, -1, -1);
        check_ramp();

        load_random();
        run_pass(-1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
- Layer-1/layer-2 back end of the CONV pipeline; sits directly downstream of the layer-0 convolution stage.
- Reads the two 64x64 layer-0 feature maps (kernel 0 and kernel 1) through the shared c-memory port.
- Applies 2x2, stride-2 max-pooling and writes each 32x32 result to its L1 bank.
- Writes the channel-interleaved flatten vector to the L2 bank, in one pass.

Parameters:
- DW, 20, data width in bits; signed 4.16 fixed point.
- AW, 12, c-memory address width.
- IN_W, 64, input map width and height; fixed power of two.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a pass.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.
- crd  out  1  c-memory read strobe.
- caddr_rd  out  AW  c-memory read address.
- cdata_rd  in  DW  c-memory read data; valid at the rising edge that ends the cycle crd was high.
- cwr  out  1  c-memory write strobe; the write is committed at the rising edge.
- caddr_wr  out  AW  c-memory write address.
- cdata_wr  out  DW  c-memory write data.
- csel  out  3  bank select, shared by reads and writes:
  - 001 = L0 kernel 0, 010 = L0 kernel 1.
  - 011 = L1 kernel 0, 100 = L1 kernel 1.
  - 101 = L2.
  - 000 = idle.

Behaviour:
- Reset (asynchronous):
  - busy, done, crd and cwr = 0; caddr_rd, caddr_wr and cdata_wr = 0; csel = 000.
  - FSM goes to IDLE and the pixel index i = 0, kernel k = 0 and sub-counter are cleared.
  - Reset mid-pass aborts immediately. No further reads or writes occur, and there is no done pulse.
- Only one bank is addressed per cycle; crd and cwr are never high in the same cycle.
- FSM states: IDLE, RD, WR1, WR2, FIN.
- IDLE:
  - All strobes are 0 and csel = 000.
  - If start = 1 at a rising edge: busy goes to 1, i = 0, k = 0, next state RD.
- RD (4 cycles, sub-counter s = 0..3):
  - crd = 1, csel = 001 + k.
  - caddr_rd = base + {0, 1, IN_W, IN_W+1}[s], where base = 2*r*IN_W + 2*c, r = i[9:5], c = i[4:0].
- Running maximum:
  - At the edge ending s = 0, max_reg is loaded with cdata_rd unconditionally; a stale value is never compared.
  - At the edges ending s = 1..3: max_reg <= (cdata_rd > max_reg, signed) ? cdata_rd : max_reg. On ties max_reg is kept.
- WR1 (1 cycle):
  - cwr = 1, csel = 011 + k, caddr_wr = zero-extended i, cdata_wr = max_reg.
- WR2 (1 cycle):
  - cwr = 1, csel = 101, caddr_wr = 2*i + k, cdata_wr = max_reg.
- After WR2:
  - If k = 0: set k = 1 and go to RD for the same i.
  - Else if i < 1023: set k = 0, i = i + 1, go to RD.
  - Else go to FIN.
- FIN (1 cycle): done = 1, busy = 0, then IDLE.
- Timing:
  - Each (i, k) takes exactly 6 cycles; a pass is 2048*6 = 12288 cycles.
  - busy is high for exactly 12288 cycles, and done follows in the next cycle.
- start while busy or in FIN is ignored. start in IDLE right after FIN begins a new pass.
- No wrap-around: the index i saturates into FIN. The last window (i = 1023) reads addresses 4030, 4031, 4094 and 4095.
- cdata_rd is sampled only at the edges ending RD cycles; its value at any other time is don't-care, including X.

Test Plan:
1. Ramp input, L0[a] = a for both banks, then start.
   - Expect L1_k[i] = base + 65, e.g. L1[0] = 0x00041 and L1[1023] = 0x00FFF.
   - Expect L2[2i] = L2[2i+1] = L1[i]; done arrives 12289 cycles after start.
2. Window {0x80000, 0xFFFFF, 0x00001, 0x7FFFF} at i = 0 (signed compare) -> L1[0] = 0x7FFFF.
   - Also all four values = 0xFFFFF -> L1[0] = 0xFFFFF.
3. Bank and address checker on every cycle -> all of the following must hold:
   - csel follows the pattern 001 x4, 011, 101, then 010 x4, 100, 101.
   - crd and cwr are never high together.
   - caddr_wr for L2 = 2i+k, with the last write at 2047.
4. Assert start at cycles 100 and 5000 while busy -> no restart; the write count stays 4096 and there is a single done pulse.
5. Assert reset asynchronously mid-pass at cycle 3000 -> all outputs are 0 within the same cycle; no writes follow.
   - A new start afterwards must give a full correct pass matching scenario 1.
6. Back-to-back passes (start in the cycle after done) with different L0 data -> the second pass's results fully overwrite the first, with no errors.
